countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 103 ++++++++++
 tb/tb_countdown_timer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer with start/pause/clear commands.
// Counts down one step per rising edge of the upstream divided-clock level.
module countdown_timer (
    input  logic       clkI,
    input  logic       rstN,
    input  logic       tickI,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic [7:0] loadVal,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       done,
    output logic       donePulse
);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} stateT;

    stateT      stateQ, stateD;
    logic [3:0] tensD, onesD;
    logic       tickD;
    logic       step;
    logic       enterDone;
    logic       runningD, doneD, donePulseD;

    // A digit above 9 is not valid BCD; saturate it to 9.
    function automatic logic [3:0] clampDigit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign step = tickI & ~tickD;

    // State, count, edge-detect and registered outputs.
    always_ff @(posedge clkI) begin
        if (!rstN) begin
            stateQ    <= StIdle;
            tens      <= 4'd0;
            ones      <= 4'd0;
            tickD     <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
            donePulse <= 1'b0;
        end else begin
            stateQ    <= stateD;
            tens      <= tensD;
            ones      <= onesD;
            tickD     <= tickI;
            running   <= runningD;
            done      <= doneD;
            donePulse <= donePulseD;
        end
    end

    // Next state and count; only the highest-priority event acts.
    always_comb begin
        stateD    = stateQ;
        tensD     = tens;
        onesD     = ones;
        enterDone = 1'b0;
        if (clear) begin
            stateD = StIdle;
            tensD  = 4'd0;
            onesD  = 4'd0;
        end else if (start) begin
            tensD = clampDigit(loadVal[7:4]);
            onesD = clampDigit(loadVal[3:0]);
            if ((tensD == 4'd0) && (onesD == 4'd0)) begin
                stateD    = StDone;
                enterDone = 1'b1;
            end else begin
                stateD = StRun;
            end
        end else if (pause) begin
            unique case (stateQ)
                StRun:   stateD = StPause;
                StPause: stateD = StRun;
                default: stateD = stateQ;
            endcase
        end else if (step && (stateQ == StRun)) begin
            if ((tens == 4'd0) && (ones <= 4'd1)) begin
                // Reaching 00 ends the run; never wrap below 00.
                tensD     = 4'd0;
                onesD     = 4'd0;
                stateD    = StDone;
                enterDone = 1'b1;
            end else if (ones == 4'd0) begin
                onesD = 4'd9;
                tensD = tens - 4'd1;
            end else begin
                onesD = ones - 4'd1;
            end
        end
    end

    // Output decodes of the next state, registered in the state block.
    always_comb begin
        runningD   = (stateD == StRun);
        doneD      = (stateD == StDone);
        donePulseD = enterDone;
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer.
module tb_countdown_timer;

    logic       clkI = 1'b0;
    logic       rstN, tickI, start, pause, clear;
    logic [7:0] loadVal;
    logic [3:0] tens, ones;
    logic       running, done, donePulse;

    int total = 0;
    int bad   = 0;
    logic [10:0] obs;

    countdown_timer dut (
        .clkI(clkI), .rstN(rstN), .tickI(tickI), .start(start), .pause(pause),
        .clear(clear), .loadVal(loadVal), .tens(tens), .ones(ones),
        .running(running), .done(done), .donePulse(donePulse)
    );

    always #5 clkI = ~clkI;

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
    task automatic cyc();
        @(posedge clkI);
        #1;
    endtask

    // One isolated tick rising edge followed by a low cycle.
    task automatic pulseTick();
        tickI = 1'b1;
        cyc();
        tickI = 1'b0;
        cyc();
    endtask

    task automatic doStart(input logic [7:0] v);
        loadVal = v;
        start   = 1'b1;
        cyc();
        start   = 1'b0;
    endtask

    // obs = {tens, ones, running, done, donePulse}
    task automatic test_reset();
        rstN = 1'b0; tickI = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0; loadVal = 8'h00;
        cyc(); cyc();
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== 11'h000) begin
            $display("FAIL reset_state: got %h want %h", obs, 11'h000); bad++;
        end
        // Reset beats start.
        start = 1'b1; loadVal = 8'h42;
        cyc();
        start = 1'b0;
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== 11'h000) begin
            $display("FAIL reset_priority: got %h want %h", obs, 11'h000); bad++;
        end
        rstN = 1'b1;
        // Pause in IDLE is ignored.
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== 11'h000) begin
            $display("FAIL idle_pause: got %h want %h", obs, 11'h000); bad++;
        end
    endtask

    task automatic test_countdown();
        logic [7:0] seq [12];
        seq = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        doStart(8'h12);
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== {8'h12, 3'b100}) begin
            $display("FAIL load_12: got %h want %h", obs, {8'h12, 3'b100}); bad++;
        end
        for (int i = 0; i < 12; i++) begin
            tickI = 1'b1;
            cyc();
            obs = {tens, ones, running, done, donePulse};
            total++;
            if (i < 11) begin
                if (obs !== {seq[i], 3'b100}) begin
                    $display("FAIL count_step%0d: got %h want %h", i, obs, {seq[i], 3'b100});
                    bad++;
                end
            end else begin
                if (obs !== {8'h00, 3'b011}) begin
                    $display("FAIL count_done: got %h want %h", obs, {8'h00, 3'b011}); bad++;
                end
            end
            tickI = 1'b0;
            cyc();
        end
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== {8'h00, 3'b010}) begin
            $display("FAIL done_held: got %h want %h", obs, {8'h00, 3'b010}); bad++;
        end
        // Steps in DONE are ignored.
        pulseTick();
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== {8'h00, 3'b010}) begin
            $display("FAIL done_step: got %h want %h", obs, {8'h00, 3'b010}); bad++;
        end
    endtask

    task automatic test_borrow();
        doStart(8'h20);
        tickI = 1'b1;
        cyc();
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== {8'h19, 3'b100}) begin
            $display("FAIL borrow: got %h want %h", obs, {8'h19, 3'b100}); bad++;
        end
        repeat (50) cyc();
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== {8'h19, 3'b100}) begin
            $display("FAIL held_tick: got %h want %h", obs, {8'h19, 3'b100}); bad++;
        end
        tickI = 1'b0;
        cyc();
    endtask

    task automatic test_pause();
        doStart(8'h07);
        pause = 1'b1; tickI = 1'b1;
        cyc();
        pause = 1'b0; tickI = 1'b0;
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== {8'h07, 3'b000}) begin
            $display("FAIL pause_step: got %h want %h", obs, {8'h07, 3'b000}); bad++;
        end
        cyc();
        repeat (3) pulseTick();
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== {8'h07, 3'b000}) begin
            $display("FAIL paused_steps: got %h want %h", obs, {8'h07, 3'b000}); bad++;
        end
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== {8'h07, 3'b100}) begin
            $display("FAIL resume: got %h want %h", obs, {8'h07, 3'b100}); bad++;
        end
        pulseTick();
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== {8'h06, 3'b100}) begin
            $display("FAIL resume_step: got %h want %h", obs, {8'h06, 3'b100}); bad++;
        end
    endtask

    task automatic test_zero_clamp();
        doStart(8'h00);
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== {8'h00, 3'b011}) begin
            $display("FAIL load_zero: got %h want %h", obs, {8'h00, 3'b011}); bad++;
        end
        cyc();
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== {8'h00, 3'b010}) begin
            $display("FAIL zero_pulse_end: got %h want %h", obs, {8'h00, 3'b010}); bad++;
        end
        doStart(8'hAF);
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== {8'h99, 3'b100}) begin
            $display("FAIL clamp_af: got %h want %h", obs, {8'h99, 3'b100}); bad++;
        end
        doStart(8'h5C);
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== {8'h59, 3'b100}) begin
            $display("FAIL clamp_5c: got %h want %h", obs, {8'h59, 3'b100}); bad++;
        end
    endtask

    task automatic test_clear_reset();
        doStart(8'h05);
        clear = 1'b1; start = 1'b1; loadVal = 8'h42;
        cyc();
        clear = 1'b0; start = 1'b0;
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== 11'h000) begin
            $display("FAIL clear_start: got %h want %h", obs, 11'h000); bad++;
        end
        doStart(8'h02);
        pulseTick();
        // Reset with a tick edge that would otherwise finish the count.
        rstN = 1'b0; tickI = 1'b1;
        cyc();
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== 11'h000) begin
            $display("FAIL reset_mid_run: got %h want %h", obs, 11'h000); bad++;
        end
        rstN = 1'b1;
        cyc();
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== 11'h000) begin
            $display("FAIL tick_after_reset: got %h want %h", obs, 11'h000); bad++;
        end
        tickI = 1'b0;
        cyc();
    endtask

    task automatic test_back_to_back();
        doStart(8'h01);
        pulseTick();
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== {8'h00, 3'b010}) begin
            $display("FAIL reach_done: got %h want %h", obs, {8'h00, 3'b010}); bad++;
        end
        loadVal = 8'h03; start = 1'b1; tickI = 1'b1;
        cyc();
        start = 1'b0; tickI = 1'b0;
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== {8'h03, 3'b100}) begin
            $display("FAIL restart_step: got %h want %h", obs, {8'h03, 3'b100}); bad++;
        end
        cyc();
        pulseTick();
        obs = {tens, ones, running, done, donePulse};
        total++;
        if (obs !== {8'h02, 3'b100}) begin
            $display("FAIL restart_count: got %h want %h", obs, {8'h02, 3'b100}); bad++;
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_borrow();
        test_pause();
        test_zero_clamp();
        test_clear_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
